fft_power_spec: RTL and testbench
=================================

Name: fft_power_spec

Overview:
- Stage directly downstream of the FFT controller and FFT register file.
- During the controller's spectrum read-out, it consumes the 256 complex FFT bins streamed from the register file.
- For each of the first 128 bins, it computes the power |X|^2 = re^2 + im^2, scales it, writes it to a 128-entry power RAM, and accumulates the frame spectral energy for the mel/log stage.

Parameters:
- DW, 16, signed width of spec_re/spec_im.
- OW, 16, unsigned width of the power word written to RAM.
- PW_SHIFT, 8, right shift applied to the 32-bit raw power before truncation to OW.
- NBIN, 256, FFT bins per frame (input count).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; clears counters and arms capture of a new frame
- spec_valid  in  1  spec_re/spec_im hold bin n this cycle (bins arrive in order 0..NBIN-1)
- spec_re  in  DW  real part, two's complement
- spec_im  in  DW  imaginary part, two's complement
- pw_wren  out  1  power RAM write strobe
- pw_addr  out  7  power RAM address (bin index 0..127)
- pw_data  out  OW  scaled power
- energy  out  OW+7  sum of the 128 written pw_data values; stable while frame_done is high or the block is idle
- frame_done  out  1  one-cycle pulse when the last write of the frame has been issued
- busy  out  1  high from frame_start until frame_done
- sat_flag  out  1  sticky per frame; set if any bin saturated (tied 0 without PW_SAT_EN)

Behaviour:
- Reset (async, reset==0): all outputs 0, state IDLE, bin counter 0, pipeline valid bits 0, energy 0.
- State IDLE:
  - spec_valid is ignored.
  - frame_start -> CAPTURE: bin_cnt<=0, energy<=0, sat_flag<=0, busy<=1.
- State CAPTURE: each spec_valid cycle accepts one bin and increments bin_cnt (9 bits).
  - Bins 0..127 enter the pipeline.
  - Bins 128..NBIN-1 are counted but discarded (Nyquist and mirror half).
  - When the accepted bin is NBIN-1 -> DRAIN.
- State DRAIN: wait until the pipeline is empty, then pulse frame_done for 1 cycle, busy<=0 -> IDLE.
- Pipeline stages:
  - S1 registers sq_re = re*re and sq_im = im*im, each 2*DW-2+1 bits unsigned (max 2^30).
  - S2 registers p = (sq_re + sq_im) >> PW_SHIFT (32-bit sum, max 2^31) and reduces it to OW bits (see Optional Feature).
  - S2 also drives pw_wren=1, pw_addr=bin index, pw_data=p.
- Latency: spec_valid at cycle t -> pw_wren at t+2. Full throughput of 1 bin/clk; gaps in spec_valid are allowed (the controller may stream every cycle).
- energy: energy <= energy + pw_data on every pw_wren. No wrap is possible, since 128*(2^OW-1) fits in OW+7 bits.
- pw_wren stays low on idle cycles; pw_addr and pw_data hold their last values.
- frame_start while CAPTURE or DRAIN:
  - Abort; in-flight pipeline entries are squashed (no pw_wren from them).
  - No frame_done for the aborted frame.
  - Counters and energy cleared; stays in CAPTURE.
- frame_start and spec_valid in the same cycle: frame_start wins. That bin is accepted as bin 0 of the new frame.
- spec_valid in DRAIN: ignored (excess bins dropped).
- Async reset mid-frame: immediate return to IDLE, outputs 0, no RAM write.

Optional Feature:
- Macro PW_SAT_EN.
- Defined: if the shifted power is >= 2^OW, pw_data = 2^OW-1 (all ones) and sat_flag is set until the next frame_start.
- Undefined: pw_data = low OW bits of the shifted power (wrap) and sat_flag is tied 0.

Test Plan:
- Reset, frame_start, 256 bins all re=256, im=0 -> 128 writes, addr 0..127, each pw_data=256 (65536>>8), first pw_wren 2 clk after first spec_valid; energy=32768; frame_done once; bins 128..255 produce no write.
- Bin 5 re=-32768, im=-32768, others 0 -> raw 2^31>>8=2^23. With PW_SAT_EN: pw_data[5]=65535, sat_flag=1, energy=65535. Without: pw_data[5]=0, sat_flag=0.
- Bin k re=k, im=-k for k<128 -> pw_data = (2k^2)>>8 (e.g. k=100 -> 78); energy = sum of the written values.
- spec_valid toggling every other cycle (controller pacing) -> same writes and values as back-to-back streaming; frame_done 2-3 clk after bin 255.
- frame_start pulse at bin 60 -> writes from bins 58/59 in flight squashed, no frame_done; the new frame restarts at addr 0 and completes normally with energy counting the new frame only.
- reset asserted at bin 90 -> all outputs 0 within the same cycle; spec_valid afterwards (no frame_start) -> no writes, busy=0.

Source files
------------

// File: rtl/fft_power_spec.sv
// fft_power_spec: per-bin power stage downstream of the FFT register file.
// It squares and sums the real and imaginary parts of the first 128 of NBIN
// streamed bins, scales the result, writes it to a 128-entry power RAM and
// accumulates the frame spectral energy.
// Optional feature: define PW_SAT_EN to saturate oversized power words and
// report them on sat_flag. Without it the word wraps and sat_flag is 0.
module fft_power_spec #(
   parameter int DW       = 16,
   parameter int OW       = 16,
   parameter int PW_SHIFT = 8,
   parameter int NBIN     = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            frame_start,
   input  logic            spec_valid,
   input  logic [DW-1:0]   spec_re,
   input  logic [DW-1:0]   spec_im,
   output logic            pw_wren,
   output logic [6:0]      pw_addr,
   output logic [OW-1:0]   pw_data,
   output logic [OW+6:0]   energy,
   output logic            frame_done,
   output logic            busy,
   output logic            sat_flag
);

   localparam int SQW  = 2*DW - 1;   // unsigned square width, max 2^(2*DW-2)
   localparam int NPOW = 128;        // bins that carry unique power

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t               state, state_nxt;
   logic [8:0]           bin_cnt;
   logic [8:0]           bin_idx;
   logic                 accept;
   logic                 take;
   logic                 last_bin;
   logic                 done_nxt;

   logic                 s1_vld;
   logic [6:0]           s1_addr;
   logic [SQW-1:0]       sq_re, sq_im;
   logic                 s2_vld;

   logic signed [2*DW-1:0] prod_re, prod_im;
   logic [2*DW-1:0]      pw_sum;
   logic [2*DW-1:0]      pw_shifted;
   logic [OW-1:0]        pw_next;

   // A bin is taken on a valid cycle while capturing; a concurrent frame_start
   // makes it bin 0 of the new frame.
   assign bin_idx  = frame_start ? 9'd0 : bin_cnt;
   assign accept   = spec_valid && (frame_start || (state == CAPTURE));
   assign take     = accept && (bin_idx < 9'(NPOW));
   assign last_bin = accept && (bin_idx == 9'(NBIN-1));

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; frame_start restarts capture from any state.
   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    ;
         CAPTURE: if (last_bin) state_nxt = DRAIN;
         DRAIN: begin
            if (!s1_vld && !s2_vld) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (frame_start) begin
         done_nxt  = 1'b0;
         state_nxt = last_bin ? DRAIN : CAPTURE;
      end
   end

   // Registered frame status: done pulse and busy flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= done_nxt;
         busy       <= (state_nxt != IDLE);
      end
   end

   // Bin counter: counts every accepted bin, including the discarded half.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           bin_cnt <= '0;
      else if (accept)      bin_cnt <= bin_idx + 9'd1;
      else if (frame_start) bin_cnt <= '0;
   end

   assign prod_re = $signed(spec_re) * $signed(spec_re);
   assign prod_im = $signed(spec_im) * $signed(spec_im);

   // Stage 1: squares of both components; frame_start squashes the old entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_vld  <= 1'b0;
         s1_addr <= '0;
         sq_re   <= '0;
         sq_im   <= '0;
      end else begin
         s1_vld <= take;
         if (take) begin
            s1_addr <= bin_idx[6:0];
            sq_re   <= prod_re[SQW-1:0];
            sq_im   <= prod_im[SQW-1:0];
         end
      end
   end

   assign pw_sum     = {1'b0, sq_re} + {1'b0, sq_im};
   assign pw_shifted = pw_sum >> PW_SHIFT;

`ifdef PW_SAT_EN
   logic pw_sat;
   assign pw_sat  = |pw_shifted[2*DW-1:OW];
   assign pw_next = pw_sat ? {OW{1'b1}} : pw_shifted[OW-1:0];

   // Sticky saturation flag, cleared at each frame start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  sat_flag <= 1'b0;
      else if (frame_start)        sat_flag <= 1'b0;
      else if (s1_vld && pw_sat)   sat_flag <= 1'b1;
   end
`else
   assign pw_next  = OW'(pw_shifted);
   assign sat_flag = 1'b0;
`endif

   // Stage 2: RAM write port; address and data hold between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_vld  <= 1'b0;
         pw_addr <= '0;
         pw_data <= '0;
      end else begin
         s2_vld <= s1_vld && !frame_start;
         if (s1_vld && !frame_start) begin
            pw_addr <= s1_addr;
            pw_data <= pw_next;
         end
      end
   end

   // A write already presented is withdrawn in the cycle a new frame starts.
   assign pw_wren = s2_vld && !frame_start;

   // Frame energy: running sum of written power words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           energy <= '0;
      else if (frame_start) energy <= '0;
      else if (pw_wren)     energy <= energy + {7'd0, pw_data};
   end

endmodule

// File: tb/tb_fft_power_spec.sv
// Testbench for fft_power_spec: a stimulus process drives frames and feeds a
// spectrum-level model that queues expected RAM writes and frame results; a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_fft_power_spec;

   localparam int DW   = 16;
   localparam int OW   = 16;
   localparam int NBIN = 256;
   localparam int NPOW = 128;

   logic            clk = 1'b0;
   logic            reset;
   logic            frame_start;
   logic            spec_valid;
   logic [DW-1:0]   spec_re, spec_im;
   logic            pw_wren;
   logic [6:0]      pw_addr;
   logic [OW-1:0]   pw_data;
   logic [OW+6:0]   energy;
   logic            frame_done;
   logic            busy;
   logic            sat_flag;

   fft_power_spec #(.DW(DW), .OW(OW), .PW_SHIFT(8), .NBIN(NBIN)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .spec_valid(spec_valid), .spec_re(spec_re), .spec_im(spec_im),
      .pw_wren(pw_wren), .pw_addr(pw_addr), .pw_data(pw_data),
      .energy(energy), .frame_done(frame_done), .busy(busy),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int addr; int data; int cyc;} wr_t;
   typedef struct {longint energy; bit sat; int cyc;} fr_t;

   wr_t wq[$];
   fr_t fq[$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Spectrum model state: which frame is open and what it has produced.
   bit     m_active = 1'b0;
   int     m_bin    = 0;
   longint m_energy = 0;
   bit     m_sat    = 1'b0;

   // Power of one bin from the arithmetic definition.
   function automatic void model_pw(input int re, input int im, output int pw, output bit sat);
      longint raw, sh;
      raw = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      sh  = raw / 256;
`ifdef PW_SAT_EN
      if (sh >= 65536) begin pw = 65535; sat = 1'b1; end
      else begin pw = int'(sh); sat = 1'b0; end
`else
      pw  = int'(sh % 65536);
      sat = 1'b0;
`endif
   endfunction

   function automatic void get_bin(input int mode, input int k, output int re, output int im);
      logic signed [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case (mode)
         0: begin re = 256; im = 0; end
         1: begin re = (k == 5) ? -32768 : 0; im = re; end
         2: begin re = k; im = -k; end
         default: begin re = int'(a); im = int'(b); end
      endcase
   endfunction

   // One clock of stimulus; the model sees exactly what the DUT will sample.
   task automatic step(input bit fs, input bit v, input int re, input int im);
      int pw;
      bit s;
      @(posedge clk);
      #1;
      frame_start = fs;
      spec_valid  = v;
      spec_re     = 16'(re);
      spec_im     = 16'(im);
      if (fs) begin
         wq.delete();
         m_active = 1'b1;
         m_bin    = 0;
         m_energy = 0;
         m_sat    = 1'b0;
      end
      if (v && m_active) begin
         model_pw(re, im, pw, s);
         if (m_bin < NPOW) begin
            wq.push_back('{m_bin, pw, cyc});
            m_energy += pw;
            m_sat    |= s;
         end
         if (m_bin == NBIN-1) begin
            fq.push_back('{m_energy, m_sat, cyc});
            m_active = 1'b0;
         end
         m_bin++;
      end
   endtask

   // gap: 0 back-to-back, 1 every other cycle, 2 random idle cycles.
   task automatic stream(input int mode, input int gap, input bit first_fs, input int count);
      int re, im;
      if (!first_fs) step(1'b1, 1'b0, 0, 0);
      for (int k = 0; k < count; k++) begin
         if (k > 0 || !first_fs) begin
            if (gap == 1) step(1'b0, 1'b0, int'($urandom_range(0, 999)), 0);
            else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 0, 0);
         end
         get_bin(mode, k, re, im);
         step(first_fs && (k == 0), 1'b1, re, im);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && (fq.size() != 0 || wq.size() != 0); i++)
         step(1'b0, 1'b0, 0, 0);
      check("frame_timeout", fq.size() + wq.size(), 0);
   endtask

   // Monitor: compares every write and every frame completion.
   wr_t m_e;
   fr_t m_f;
   always @(negedge clk) begin
      if (reset) begin
         if (pw_wren) begin
            if (wq.size() == 0) check("spurious_wr", pw_wren, 0);
            else begin
               m_e = wq.pop_front();
               check("wr_addr", pw_addr, m_e.addr);
               check("wr_data", pw_data, m_e.data);
               check("wr_latency", cyc - m_e.cyc, 2);
            end
         end
         if (frame_done) begin
            if (fq.size() == 0) check("spurious_done", frame_done, 0);
            else begin
               m_f = fq.pop_front();
               check("energy", energy, m_f.energy);
               check("sat_flag", sat_flag, m_f.sat);
               check("done_latency_2to3", (cyc - m_f.cyc >= 2) && (cyc - m_f.cyc <= 3), 1);
               check("writes_before_done", wq.size(), 0);
            end
         end
      end
   end

   initial begin
      reset = 1'b0; frame_start = 1'b0; spec_valid = 1'b0;
      spec_re = '0; spec_im = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pw_wren", pw_wren, 0);
      check("rst_pw_addr", pw_addr, 0);
      check("rst_pw_data", pw_data, 0);
      check("rst_energy", energy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_sat_flag", sat_flag, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Idle: valid bins without frame_start produce nothing.
      repeat (5) step(1'b0, 1'b1, 256, 0);

      stream(0, 0, 1'b0, NBIN);  wait_done();   // constant 256+0j
      stream(1, 0, 1'b0, NBIN);  wait_done();   // single full-scale bin
      stream(2, 0, 1'b1, NBIN);  wait_done();   // k - jk, start on bin 0
      stream(2, 1, 1'b0, NBIN);  wait_done();   // same, paced

      // Abort at bin 60; the new frame starts with that bin as bin 0.
      stream(3, 0, 1'b0, 60);
      check("busy_mid_frame", busy, 1);
      stream(3, 0, 1'b1, NBIN);  wait_done();

      for (int f = 0; f < 3; f++) begin
         stream(3, 2, 1'($urandom_range(0, 1)), NBIN);
         wait_done();
      end

      // Asynchronous reset in the middle of a frame.
      stream(3, 0, 1'b0, 90);
      @(posedge clk);
      #1;
      reset = 1'b0;
      wq.delete(); fq.delete(); m_active = 1'b0;
      #1;
      check("arst_pw_wren", pw_wren, 0);
      check("arst_busy", busy, 0);
      check("arst_energy", energy, 0);
      check("arst_pw_data", pw_data, 0);
      check("arst_pw_addr", pw_addr, 0);
      check("arst_frame_done", frame_done, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 20; i++)
         step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 30000)), 0);
      step(1'b0, 1'b0, 0, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_energy", energy, 0);

      check("final_wq_empty", wq.size(), 0);
      check("final_fq_empty", fq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
